// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, branch flush and EX forwarding control
// Keeps a shadow pipeline of destination tags (EX/MEM/WB) and two saturating event counters.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_de,
  input  logic [4:0]       rs2_de,
  input  logic             uses_rs1_de,
  input  logic             uses_rs2_de,
  input  logic [4:0]       rd_de,
  input  logic             RuWr_de,
  input  logic [1:0]       RUDataWrSrc_de,
  input  logic [4:0]       rs1_ex,
  input  logic [4:0]       rs2_ex,
  input  logic             branch_taken_ex,
  input  logic             clr_cnt,
  output logic             stall_if,
  output logic             stall_de,
  output logic             flush_if,
  output logic             flush_de,
  output logic [1:0]       fwdA_ex,
  output logic [1:0]       fwdB_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_wr, ex_ld, mem_wr, mem_ld, wb_wr;
  logic       lu, bf;
  logic       mem_fwd_ok, wb_fwd_ok;

  assign bf = branch_taken_ex;
  assign lu = ex_ld & ex_wr & (ex_rd != 5'd0) &
              ((uses_rs1_de & (rs1_de == ex_rd)) | (uses_rs2_de & (rs2_de == ex_rd)));

  // A load sitting in MEM has no data yet, so only ALU/PC+4 results forward from MEM.
  assign mem_fwd_ok = mem_wr & ~mem_ld & (mem_rd != 5'd0);
  assign wb_fwd_ok  = wb_wr & (wb_rd != 5'd0);

  always_comb begin
    stall_if = 1'b0;
    stall_de = 1'b0;
    flush_if = 1'b0;
    flush_de = 1'b0;
    fwdA_ex  = 2'b00;
    fwdB_ex  = 2'b00;
    if (rst_n) begin
      if (bf) begin
        flush_if = 1'b1;
        flush_de = 1'b1;
      end else if (lu) begin
        stall_if = 1'b1;
        stall_de = 1'b1;
        flush_de = 1'b1;
      end

      if (mem_fwd_ok && (mem_rd == rs1_ex))     fwdA_ex = 2'b01;
      else if (wb_fwd_ok && (wb_rd == rs1_ex))  fwdA_ex = 2'b10;

      if (mem_fwd_ok && (mem_rd == rs2_ex))     fwdB_ex = 2'b01;
      else if (wb_fwd_ok && (wb_rd == rs2_ex))  fwdB_ex = 2'b10;
    end
  end

  // WB never forwards differently for loads, so its ld bit is not kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd  <= 5'd0;
      ex_wr  <= 1'b0;
      ex_ld  <= 1'b0;
      mem_rd <= 5'd0;
      mem_wr <= 1'b0;
      mem_ld <= 1'b0;
      wb_rd  <= 5'd0;
      wb_wr  <= 1'b0;
    end else begin
      wb_rd  <= mem_rd;
      wb_wr  <= mem_wr;
      mem_rd <= ex_rd;
      mem_wr <= ex_wr;
      mem_ld <= ex_ld;
      if (flush_de) begin
        ex_rd <= 5'd0;
        ex_wr <= 1'b0;
        ex_ld <= 1'b0;
      end else begin
        ex_rd <= rd_de;
        ex_wr <= RuWr_de;
        ex_ld <= (RUDataWrSrc_de == 2'b01);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_de && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_if && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
// Instruction-history model checked every negedge, plus directed literal checks.
module tb_hazard_unit;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [4:0]       rs1_de = '0, rs2_de = '0, rd_de = '0, rs1_ex = '0, rs2_ex = '0;
  logic             uses_rs1_de = 1'b0, uses_rs2_de = 1'b0, RuWr_de = 1'b0;
  logic [1:0]       RUDataWrSrc_de = '0;
  logic             branch_taken_ex = 1'b0, clr_cnt = 1'b0;
  logic             stall_if, stall_de, flush_if, flush_de;
  logic [1:0]       fwdA_ex, fwdB_ex;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_de(rs1_de), .rs2_de(rs2_de), .uses_rs1_de(uses_rs1_de), .uses_rs2_de(uses_rs2_de),
    .rd_de(rd_de), .RuWr_de(RuWr_de), .RUDataWrSrc_de(RUDataWrSrc_de),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .branch_taken_ex(branch_taken_ex), .clr_cnt(clr_cnt),
    .stall_if(stall_if), .stall_de(stall_de), .flush_if(flush_if), .flush_de(flush_de),
    .fwdA_ex(fwdA_ex), .fwdB_ex(fwdB_ex), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // hist[0] = instruction now in EX, hist[1] = in MEM, hist[2] = in WB
  logic [4:0] h_rd[3];
  logic       h_wr[3];
  logic       h_ld[3];
  int         m_stall, m_flush;
  logic       m_bub;

  function automatic logic producer(input int k);
    return h_wr[k] && (h_rd[k] != 5'd0);
  endfunction

  function automatic logic m_lu();
    return producer(0) && h_ld[0] &&
           ((uses_rs1_de && rs1_de == h_rd[0]) || (uses_rs2_de && rs2_de == h_rd[0]));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (producer(1) && !h_ld[1] && h_rd[1] == r) return 2'b01;
    if (producer(2) && h_rd[2] == r) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        h_rd[k] = 5'd0; h_wr[k] = 1'b0; h_ld[k] = 1'b0;
      end
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_bub = branch_taken_ex || m_lu();
      if (clr_cnt) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (!branch_taken_ex && m_lu() && m_stall < CMAX) m_stall++;
        if (branch_taken_ex && m_flush < CMAX) m_flush++;
      end
      for (int k = 2; k > 0; k--) begin
        h_rd[k] = h_rd[k-1]; h_wr[k] = h_wr[k-1]; h_ld[k] = h_ld[k-1];
      end
      h_rd[0] = m_bub ? 5'd0 : rd_de;
      h_wr[0] = m_bub ? 1'b0 : RuWr_de;
      h_ld[0] = m_bub ? 1'b0 : (RUDataWrSrc_de == 2'b01);
    end
  end

  always @(negedge clk) begin
    logic e_lu, e_bf;
    e_lu = rst_n && m_lu();
    e_bf = rst_n && branch_taken_ex;
    chk("m_stall_if", {31'd0, stall_if}, {31'd0, !e_bf && e_lu});
    chk("m_stall_de", {31'd0, stall_de}, {31'd0, !e_bf && e_lu});
    chk("m_flush_if", {31'd0, flush_if}, {31'd0, e_bf});
    chk("m_flush_de", {31'd0, flush_de}, {31'd0, e_bf || e_lu});
    chk("m_fwdA", {30'd0, fwdA_ex}, rst_n ? {30'd0, m_fwd(rs1_ex)} : 32'd0);
    chk("m_fwdB", {30'd0, fwdB_ex}, rst_n ? {30'd0, m_fwd(rs2_ex)} : 32'd0);
    chk("m_stall_cnt", {28'd0, stall_cnt}, m_stall);
    chk("m_flush_cnt", {28'd0, flush_cnt}, m_flush);
  end

  task automatic cyc(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                     input logic [4:0] rd, input logic wr, input logic [1:0] src,
                     input logic [4:0] r1x, input logic [4:0] r2x, input logic br, input logic clr);
    @(posedge clk);
    #1;
    rs1_de = r1; uses_rs1_de = u1; rs2_de = r2; uses_rs2_de = u2;
    rd_de = rd; RuWr_de = wr; RUDataWrSrc_de = src;
    rs1_ex = r1x; rs2_ex = r2x; branch_taken_ex = br; clr_cnt = clr;
    #3;
  endtask

  task automatic nop(input logic [4:0] r1x, input logic [4:0] r2x);
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, r1x, r2x, 1'b0, 1'b0);
  endtask

  initial begin
    // reset with a branch and a would-be hazard on the inputs
    #1;
    rst_n = 1'b0;
    branch_taken_ex = 1'b1; uses_rs1_de = 1'b1; rs1_de = 5'd5; rs1_ex = 5'd5;
    #2;
    chk("rst_flush_if", {31'd0, flush_if}, 32'd0);
    chk("rst_flush_de", {31'd0, flush_de}, 32'd0);
    chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {28'd0, flush_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    branch_taken_ex = 1'b0; uses_rs1_de = 1'b0; rs1_de = 5'd0; rs1_ex = 5'd0;
    rst_n = 1'b1;
    nop(5'd0, 5'd0);
    nop(5'd0, 5'd0);
    chk("idle_flush_cnt", {28'd0, flush_cnt}, 32'd0);
    chk("idle_fwdA", {30'd0, fwdA_ex}, 32'd0);

    // load-use: lw x5 then add reading x5
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("lw_no_stall", {31'd0, stall_de}, 32'd0);
    cyc(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("lu_stall_if", {31'd0, stall_if}, 32'd1);
    chk("lu_stall_de", {31'd0, stall_de}, 32'd1);
    chk("lu_flush_de", {31'd0, flush_de}, 32'd1);
    chk("lu_flush_if", {31'd0, flush_if}, 32'd0);
    cyc(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("lu_one_cycle", {31'd0, stall_de}, 32'd0);
    chk("lu_bubble_flush_de", {31'd0, flush_de}, 32'd0);
    // add now in EX, load in WB; DE = add x7
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'b00, 5'd5, 5'd0, 1'b0, 1'b0);
    chk("lu_fwdA_wb", {30'd0, fwdA_ex}, 32'd2);
    chk("lu_stall_cnt", {28'd0, stall_cnt}, 32'd1);

    // ALU forwarding: sub reads x7, then or reads x7
    cyc(5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("alu_no_stall", {31'd0, stall_de}, 32'd0);
    cyc(5'd0, 1'b0, 5'd7, 1'b1, 5'd9, 1'b1, 2'b00, 5'd0, 5'd7, 1'b0, 1'b0);
    chk("alu_fwdB_mem", {30'd0, fwdB_ex}, 32'd1);
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'b00, 5'd0, 5'd7, 1'b0, 1'b0);
    chk("alu_fwdB_wb", {30'd0, fwdB_ex}, 32'd2);
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    nop(5'd0, 5'd0);
    nop(5'd7, 5'd7);
    chk("prio_fwdA_mem", {30'd0, fwdA_ex}, 32'd1);
    chk("prio_fwdB_mem", {30'd0, fwdB_ex}, 32'd1);

    // x0 guard: ALU write x0, load x0, consumer of x0
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'b01, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc(5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("x0_no_stall", {31'd0, stall_de}, 32'd0);
    chk("x0_fwdA_mem", {30'd0, fwdA_ex}, 32'd0);
    nop(5'd0, 5'd0);
    chk("x0_fwdB_wb", {30'd0, fwdB_ex}, 32'd0);

    // branch over load-use, counters cleared first
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'b01, 5'd0, 5'd0, 1'b0, 1'b1);
    cyc(5'd3, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("bf_flush_if", {31'd0, flush_if}, 32'd1);
    chk("bf_flush_de", {31'd0, flush_de}, 32'd1);
    chk("bf_stall_de", {31'd0, stall_de}, 32'd0);
    chk("bf_stall_if", {31'd0, stall_if}, 32'd0);
    nop(5'd0, 5'd0);
    chk("bf_flush_cnt", {28'd0, flush_cnt}, 32'd1);
    chk("bf_stall_cnt", {28'd0, stall_cnt}, 32'd0);

    // saturation: lw x4 reading x4 stalls every other cycle
    for (int i = 0; i < 40; i++)
      cyc(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 2'b01, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 2'b01, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("sat_stall_cnt", {28'd0, stall_cnt}, 32'd15);
    chk("sat_no_stall", {31'd0, stall_de}, 32'd0);
    cyc(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 2'b01, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("clr_stall_active", {31'd0, stall_de}, 32'd1);
    chk("clr_pre_cnt", {28'd0, stall_cnt}, 32'd15);
    nop(5'd0, 5'd0);
    chk("clr_stall_cnt", {28'd0, stall_cnt}, 32'd0);

    // reset asserted mid-stall
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("mid_stall_pre", {31'd0, stall_de}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall_de", {31'd0, stall_de}, 32'd0);
    chk("mid_rst_stall_if", {31'd0, stall_if}, 32'd0);
    chk("mid_rst_flush_de", {31'd0, flush_de}, 32'd0);
    @(posedge clk);
    #1;
    rs1_de = 5'd0; uses_rs1_de = 1'b0; rd_de = 5'd0; RuWr_de = 1'b0;
    rst_n = 1'b1;
    nop(5'd0, 5'd0);
    nop(5'd0, 5'd0);
    chk("post_rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
